// File: rtl/i2c_reg_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_reg_sequencer
// Turns one register-access request into the ordered byte-level command
// stream for the downstream I2C byte controller, one command in flight.
//   write: START, WR {dev,0}, WR reg, WR wdata, STOP
//   read : START, WR {dev,0}, WR reg, START, WR {dev,1}, RD (nack), STOP
// A NACK on any written byte skips to STOP; a stall longer than
// TIMEOUT_CYCLES on any command abandons the transfer without a STOP.
//
// Ports
//   CLK, NRST                  clock, synchronous active-low reset
//   i_req_valid / o_req_ready  request handshake (ready only when idle)
//   i_req_rnw                  1 = register read, 0 = register write
//   i_req_dev / i_req_reg      7-bit device address, register address
//   i_req_wdata                write data (ignored for reads)
//   o_cmd_valid / i_cmd_ready  command handshake towards the controller
//   o_cmd_op                   0 START, 1 STOP, 2 WRITE byte, 3 READ byte
//   o_cmd_data                 byte for WRITE, 0 for other ops
//   o_cmd_nack                 READ only: master NACKs the byte
//   i_rsp_valid                controller finished the accepted command
//   i_rsp_data / i_rsp_nack    read byte / target NACK on a write
//   o_busy                     acceptance through DONE cycle inclusive
//   o_done                     single-cycle completion pulse
//   o_rdata                    read result, updated only on a clean read
//   o_err                      00 ok, 01 addr NACK, 10 reg/data NACK, 11 timeout
// -----------------------------------------------------------------------------
module i2c_reg_sequencer #(
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic       CLK,
  input  logic       NRST,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_rnw,
  input  logic [6:0] i_req_dev,
  input  logic [7:0] i_req_reg,
  input  logic [7:0] i_req_wdata,
  output logic       o_cmd_valid,
  input  logic       i_cmd_ready,
  output logic [1:0] o_cmd_op,
  output logic [7:0] o_cmd_data,
  output logic       o_cmd_nack,
  input  logic       i_rsp_valid,
  input  logic [7:0] i_rsp_data,
  input  logic       i_rsp_nack,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rdata,
  output logic [1:0] o_err
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The timer fires on the TIMEOUT_CYCLES-th stalled cycle of a phase.
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_READ  = 2'd3;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_ADDR = 2'b01;
  localparam logic [1:0] ERR_DATA = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DEVW, S_REG, S_WDATA,
    S_RSTART, S_DEVR, S_RDATA, S_STOP, S_DONE
  } state_t;

  state_t          r_state;
  logic            r_wait;       // 0 = ISSUE phase, 1 = WAIT phase
  logic [TW-1:0]   r_timer;
  logic            r_rnw;
  logic [6:0]      r_dev;
  logic [7:0]      r_reg;
  logic [7:0]      r_wdata;
  logic [7:0]      r_hold;       // read byte parked until DONE decides
  logic [1:0]      r_err_pend;   // NACK class seen so far in this transfer
  logic            r_req_ready;
  logic            r_cmd_valid;
  logic [1:0]      r_cmd_op;
  logic [7:0]      r_cmd_data;
  logic            r_cmd_nack;
  logic            r_busy;
  logic            r_done;
  logic [7:0]      r_rdata;
  logic [1:0]      r_err;

  state_t          w_next;
  logic [1:0]      w_nack_err;
  logic [1:0]      w_op;
  logic [7:0]      w_data;
  logic            w_nack_bit;
  logic            w_tmo;

  assign w_tmo = (TIMEOUT_CYCLES != 0) && (r_timer == TLIM);

  // Next command state after the current command completes (or after accept).
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:   w_next = S_START;
      S_START:  w_next = S_DEVW;
      S_DEVW:   w_next = i_rsp_nack ? S_STOP : S_REG;
      S_REG:    w_next = i_rsp_nack ? S_STOP : (r_rnw ? S_RSTART : S_WDATA);
      S_WDATA:  w_next = S_STOP;
      S_RSTART: w_next = S_DEVR;
      S_DEVR:   w_next = i_rsp_nack ? S_STOP : S_RDATA;
      S_RDATA:  w_next = S_STOP;
      S_STOP:   w_next = S_DONE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Classify a NACK: address bytes vs register/data bytes.
  always_comb begin
    w_nack_err = ERR_OK;
    case (r_state)
      S_DEVW, S_DEVR: begin
        if (i_rsp_nack) w_nack_err = ERR_ADDR;
        else            w_nack_err = ERR_OK;
      end
      S_REG, S_WDATA: begin
        if (i_rsp_nack) w_nack_err = ERR_DATA;
        else            w_nack_err = ERR_OK;
      end
      default: w_nack_err = ERR_OK;
    endcase
  end

  // Command fields for the state about to be issued.
  always_comb begin
    w_op       = OP_WRITE;
    w_data     = 8'h00;
    w_nack_bit = 1'b0;
    case (w_next)
      S_START, S_RSTART: w_op = OP_START;
      S_STOP:            w_op = OP_STOP;
      S_RDATA: begin
        w_op       = OP_READ;
        w_nack_bit = 1'b1;    // single-byte read: master NACKs it
      end
      S_DEVW:  w_data = {r_dev, 1'b0};
      S_REG:   w_data = r_reg;
      S_WDATA: w_data = r_wdata;
      S_DEVR:  w_data = {r_dev, 1'b1};
      default: w_op = OP_WRITE;
    endcase
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      r_state     <= S_IDLE;
      r_wait      <= 1'b0;
      r_timer     <= {TW{1'b0}};
      r_rnw       <= 1'b0;
      r_dev       <= 7'h00;
      r_reg       <= 8'h00;
      r_wdata     <= 8'h00;
      r_hold      <= 8'h00;
      r_err_pend  <= ERR_OK;
      r_req_ready <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_op    <= 2'd0;
      r_cmd_data  <= 8'h00;
      r_cmd_nack  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rdata     <= 8'h00;
      r_err       <= ERR_OK;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
          if (r_req_ready && i_req_valid) begin
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_rnw       <= i_req_rnw;
            r_dev       <= i_req_dev;
            r_reg       <= i_req_reg;
            r_wdata     <= i_req_wdata;
            r_hold      <= 8'h00;
            r_err_pend  <= ERR_OK;
            r_state     <= w_next;
            r_wait      <= 1'b0;
            r_timer     <= {TW{1'b0}};
            r_cmd_valid <= 1'b1;
            r_cmd_op    <= w_op;
            r_cmd_data  <= w_data;
            r_cmd_nack  <= w_nack_bit;
          end else begin
            r_req_ready <= 1'b1;
          end
        end

        S_DONE: begin
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end

        default: begin
          if (!r_wait) begin
            // ISSUE: hold the command until the controller takes it.
            if (i_cmd_ready) begin
              r_cmd_valid <= 1'b0;
              r_wait      <= 1'b1;
              r_timer     <= {TW{1'b0}};
            end else if (w_tmo) begin
              r_cmd_valid <= 1'b0;
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_err       <= ERR_TMO;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end else if (i_rsp_valid) begin
            // WAIT: response arrived; the next command goes out next cycle.
            r_wait  <= 1'b0;
            r_timer <= {TW{1'b0}};
            if (r_state == S_STOP) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= r_err_pend;
              if (r_rnw && (r_err_pend == ERR_OK)) begin
                r_rdata <= r_hold;
              end
            end else begin
              if (w_nack_err != ERR_OK) begin
                r_err_pend <= w_nack_err;
              end
              if (r_state == S_RDATA) begin
                r_hold <= i_rsp_data;
              end
              r_state     <= w_next;
              r_cmd_valid <= 1'b1;
              r_cmd_op    <= w_op;
              r_cmd_data  <= w_data;
              r_cmd_nack  <= w_nack_bit;
            end
          end else if (w_tmo) begin
            // Abandon without STOP; a timeout overrides any pending NACK code.
            r_wait  <= 1'b0;
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= ERR_TMO;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_cmd_valid = r_cmd_valid;
  assign o_cmd_op    = r_cmd_op;
  assign o_cmd_data  = r_cmd_data;
  assign o_cmd_nack  = r_cmd_nack;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_rdata     = r_rdata;
  assign o_err       = r_err;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_i2c_reg_sequencer
// The bench plays both the host and the I2C byte controller. For each request
// it builds the expected command list from the bus-level rules (write and
// read byte sequences, truncate to STOP after a NACKed byte, truncate with no
// STOP on a timeout) and compares every command, plus the DONE results.
// -----------------------------------------------------------------------------
module tb_i2c_reg_sequencer;

  localparam int TMO = 16;
  localparam logic [1:0] C_START = 2'd0;
  localparam logic [1:0] C_STOP  = 2'd1;
  localparam logic [1:0] C_WRITE = 2'd2;
  localparam logic [1:0] C_READ  = 2'd3;

  logic       CLK = 1'b0;
  logic       NRST;
  logic       req_valid, req_rnw;
  logic [6:0] req_dev;
  logic [7:0] req_reg, req_wdata;
  logic       cmd_ready;
  logic       rsp_valid, rsp_nack;
  logic [7:0] rsp_data;
  logic       o_req_ready, o_cmd_valid, o_cmd_nack, o_busy, o_done;
  logic [1:0] o_cmd_op, o_err;
  logic [7:0] o_cmd_data, o_rdata;

  int         n_checks = 0;
  int         n_err    = 0;
  logic [7:0] exp_rdata;
  int         rsel;

  i2c_reg_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .NRST(NRST),
    .i_req_valid(req_valid), .o_req_ready(o_req_ready), .i_req_rnw(req_rnw),
    .i_req_dev(req_dev), .i_req_reg(req_reg), .i_req_wdata(req_wdata),
    .o_cmd_valid(o_cmd_valid), .i_cmd_ready(cmd_ready), .o_cmd_op(o_cmd_op),
    .o_cmd_data(o_cmd_data), .o_cmd_nack(o_cmd_nack),
    .i_rsp_valid(rsp_valid), .i_rsp_data(rsp_data), .i_rsp_nack(rsp_nack),
    .o_busy(o_busy), .o_done(o_done), .o_rdata(o_rdata), .o_err(o_err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [10:0] mk(input logic [1:0] op, input logic nk, input logic [7:0] d);
    return {op, nk, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hard_reset();
    NRST = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; req_valid = 1'b0;
    repeat (2) @(negedge CLK);
    NRST = 1'b1;
    @(negedge CLK);
    exp_rdata = 8'h00;
  endtask

  // Called on the negedge where DONE is expected.
  task automatic finish_txn(input logic [1:0] e_err, input logic [7:0] e_rd);
    chk("done_pulse", 32'(o_done), 32'd1);
    chk("done_busy",  32'(o_busy), 32'd1);
    chk("done_ready", 32'(o_req_ready), 32'd0);
    chk("done_err",   32'(o_err), 32'(e_err));
    chk("done_rdata", 32'(o_rdata), 32'(e_rd));
    chk("done_cmdv",  32'(o_cmd_valid), 32'd0);
    @(negedge CLK);
    chk("idle_done",  32'(o_done), 32'd0);
    chk("idle_busy",  32'(o_busy), 32'd0);
    chk("idle_ready", 32'(o_req_ready), 32'd1);
    chk("idle_err",   32'(o_err), 32'(e_err));
    chk("idle_rdata", 32'(o_rdata), 32'(e_rd));
    exp_rdata = e_rd;
  endtask

  // Count stalled cycles until DONE; cmd_valid must stay at exp_v meanwhile.
  task automatic tmo_wait(input logic exp_v);
    int cnt;
    cnt = 0;
    while (o_done !== 1'b1 && cnt < 40) begin
      chk("tmo_cmdv", 32'(o_cmd_valid), 32'(exp_v));
      @(negedge CLK);
      cnt++;
    end
    chk("tmo_cycles", 32'(cnt), 32'(TMO));
  endtask

  // nack_w : which WRITE byte (0-based) the target NACKs, -1 for none
  // tmo_ci : command index at which the controller stalls, -1 for none
  // tmo_mode: 0 = withhold response, 1 = withhold CMD_READY
  // stall_fix: fixed CMD_READY delay, -1 for random
  task automatic run_txn(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input logic [7:0] rb, input int nack_w,
                         input int tmo_ci, input int tmo_mode, input int stall_fix);
    logic [10:0] full[$];
    logic [10:0] expq[$];
    logic [10:0] cur;
    int          nack_ci, wcnt, cnt, stall, dly;
    logic [1:0]  e_err;
    logic [7:0]  e_rd;

    // Reference: the bus-level byte sequence for this request.
    full.push_back(mk(C_START, 1'b0, 8'h00));
    full.push_back(mk(C_WRITE, 1'b0, {dev, 1'b0}));
    full.push_back(mk(C_WRITE, 1'b0, rg));
    if (rnw) begin
      full.push_back(mk(C_START, 1'b0, 8'h00));
      full.push_back(mk(C_WRITE, 1'b0, {dev, 1'b1}));
      full.push_back(mk(C_READ,  1'b1, 8'h00));
    end else begin
      full.push_back(mk(C_WRITE, 1'b0, wd));
    end
    full.push_back(mk(C_STOP, 1'b0, 8'h00));

    nack_ci = -1;
    wcnt    = 0;
    for (int i = 0; i < full.size(); i++) begin
      if (full[i][10:9] == C_WRITE) begin
        if (wcnt == nack_w) nack_ci = i;
        wcnt++;
      end
    end

    e_err = 2'b00;
    if (nack_ci >= 0) begin
      for (int i = 0; i <= nack_ci; i++) expq.push_back(full[i]);
      expq.push_back(mk(C_STOP, 1'b0, 8'h00));
      // A byte right after a START is an address byte.
      e_err = (full[nack_ci-1][10:9] == C_START) ? 2'b01 : 2'b10;
    end else begin
      expq = full;
    end
    if (tmo_ci >= 0) begin
      while (expq.size() > tmo_ci + 1) void'(expq.pop_back());
      e_err = 2'b11;
    end
    e_rd = (rnw && e_err == 2'b00) ? rb : exp_rdata;

    cnt = 0;
    while (o_req_ready !== 1'b1 && cnt < 60) begin
      @(negedge CLK);
      cnt++;
    end
    chk("req_ready", 32'(o_req_ready), 32'd1);
    req_rnw = rnw; req_dev = dev; req_reg = rg; req_wdata = wd; req_valid = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    req_dev = 7'($urandom); req_reg = 8'($urandom); req_wdata = 8'($urandom); req_rnw = 1'($urandom);
    chk("acc_ready", 32'(o_req_ready), 32'd0);
    chk("acc_busy",  32'(o_busy), 32'd1);

    for (int i = 0; i < expq.size(); i++) begin
      chk("cmd_valid", 32'(o_cmd_valid), 32'd1);
      if (o_cmd_valid !== 1'b1) begin
        hard_reset();
        return;
      end
      cur = {o_cmd_op, o_cmd_nack, o_cmd_data};
      chk("cmd", 32'(cur), 32'(expq[i]));
      if (i == tmo_ci && tmo_mode == 1) begin
        tmo_wait(1'b1);
        finish_txn(e_err, e_rd);
        return;
      end
      stall = (stall_fix >= 0) ? stall_fix : int'($urandom_range(0, 3));
      for (int s = 0; s < stall; s++) begin
        // Response noise while a command is still being offered is ignored.
        rsp_valid = 1'($urandom); rsp_nack = 1'($urandom); rsp_data = 8'($urandom);
        @(negedge CLK);
        chk("cmd_hold", 32'({o_cmd_valid, o_cmd_op, o_cmd_nack, o_cmd_data}), 32'({1'b1, cur}));
      end
      rsp_valid = 1'b0;
      cmd_ready = 1'b1;
      @(negedge CLK);
      cmd_ready = 1'b0;
      chk("cmd_drop", 32'(o_cmd_valid), 32'd0);
      if (i == tmo_ci) begin
        tmo_wait(1'b0);
        finish_txn(e_err, e_rd);
        return;
      end
      dly = int'($urandom_range(0, 4));
      for (int s = 0; s < dly; s++) begin
        rsp_nack = 1'($urandom); rsp_data = 8'($urandom);
        @(negedge CLK);
      end
      chk("rsp_gap", 32'(o_cmd_valid), 32'd0);
      rsp_valid = 1'b1;
      rsp_nack  = (cur[10:9] == C_WRITE) ? (i == nack_ci) : 1'($urandom);
      rsp_data  = (cur[10:9] == C_READ) ? rb : 8'($urandom);
      @(negedge CLK);
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
    end
    finish_txn(e_err, e_rd);
  endtask

  initial begin
    NRST = 1'b0; req_valid = 1'b0; req_rnw = 1'b0; req_dev = 7'h00; req_reg = 8'h00;
    req_wdata = 8'h00; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'h00;
    exp_rdata = 8'h00;

    // Reset values.
    repeat (3) @(negedge CLK);
    chk("rst_outs", 32'({o_req_ready, o_cmd_valid, o_cmd_op, o_cmd_data, o_cmd_nack,
                         o_busy, o_done, o_rdata, o_err}), 32'd0);
    NRST = 1'b1;
    @(negedge CLK);
    chk("rst_rel_ready", 32'(o_req_ready), 32'd1);
    chk("rst_rel_busy",  32'(o_busy), 32'd0);

    // Directed cases.
    run_txn(1'b1, 7'h68, 8'h75, 8'h00, 8'h71, -1, -1, 0, -1);  // clean read
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, -1, 0, -1);  // clean write, RDATA held
    run_txn(1'b0, 7'h2A, 8'h01, 8'h02, 8'h00,  0, -1, 0, -1);  // address NACK
    run_txn(1'b0, 7'h11, 8'h22, 8'h33, 8'h00,  2, -1, 0, -1);  // data NACK
    run_txn(1'b1, 7'h3C, 8'h40, 8'h00, 8'h99,  1, -1, 0, -1);  // reg NACK on read
    run_txn(1'b1, 7'h3C, 8'h41, 8'h00, 8'h98,  2, -1, 0, -1);  // read-address NACK
    run_txn(1'b1, 7'h7F, 8'hFF, 8'h00, 8'h5A, -1, -1, 0,  5);  // CMD_READY held off 5 cycles
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, -1,  0, 0, -1);  // no response to START
    run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00,  0,  2, 1, -1);  // STOP stalls after NACK
    run_txn(1'b1, 7'h21, 8'h05, 8'h00, 8'hE7, -1,  5, 0, -1);  // no response to READ

    // Randomized requests.
    for (int t = 0; t < 14; t++) begin
      rsel = int'($urandom_range(0, 5));
      run_txn(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              (rsel < 3) ? rsel : -1, -1, 0, -1);
    end

    // Reset in the middle of a read: outputs return to reset values at once.
    run_txn(1'b1, 7'h0F, 8'h0E, 8'h00, 8'hC3, -1, -1, 0, -1);
    req_rnw = 1'b1; req_dev = 7'h0F; req_reg = 8'h0E; req_valid = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    cmd_ready = 1'b1;
    @(negedge CLK);
    cmd_ready = 1'b0;
    rsp_valid = 1'b1;
    @(negedge CLK);
    rsp_valid = 1'b0;
    chk("mr_cmdv", 32'(o_cmd_valid), 32'd1);
    NRST = 1'b0;
    @(negedge CLK);
    chk("mr_outs", 32'({o_req_ready, o_cmd_valid, o_cmd_op, o_cmd_data, o_cmd_nack,
                        o_busy, o_done, o_rdata, o_err}), 32'd0);
    NRST = 1'b1;
    @(negedge CLK);
    chk("mr_ready", 32'(o_req_ready), 32'd1);
    exp_rdata = 8'h00;
    run_txn(1'b0, 7'h12, 8'h34, 8'h56, 8'h00, -1, -1, 0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of run, expected finish before time limit");
    $fatal(1, "time limit reached");
  end

endmodule
